data_bus_arbiter: RTL
=====================

// Module: data_bus_arbiter
// PURPOSE
//   Shares one 32-bit byte-addressable data memory slave port between two masters:
//   M0 = pipeline load/store unit, M1 = DMA/debug port.
//   Round-robin or fixed-priority grant with a bounded burst length and a lock for atomic RMW.
//   Sits between the masters and the data memory, which reads combinationally and writes on posedge.
// PARAMETERS
//   ADDR_WIDTH  32  address width, passed through unchanged
//   MAX_BURST   4   max consecutive transfers for one owner while the other master waits (>=1)
//   FIXED_PRIO  0   0 = round-robin; 1 = M0 always wins an idle-cycle tie
// PORTS
//   i_clock        in   1           clock, all state on rising edge
//   i_reset        in   1           asynchronous reset, active-high
//   i_mX_req       in   1           X=0,1: transfer request, held until o_mX_ack or withdrawn
//   i_mX_lock      in   1           keep ownership while req held (no preemption)
//   i_mX_we        in   1           1 = write, 0 = read
//   i_mX_access    in   2           0 = byte, 1 = half, 2 = word
//   i_mX_addr      in   ADDR_WIDTH  byte address
//   i_mX_wdata     in   32          write data
//   o_mX_ack       out  1           transfer performed this cycle
//   o_mX_rdata     out  32          read data, valid when o_mX_ack=1 and i_mX_we=0
//   o_s_addr       out  ADDR_WIDTH  slave address
//   o_s_we         out  1           slave write enable
//   o_s_access     out  2           slave access size
//   o_s_wdata      out  32          slave write data
//   i_s_rdata      in   32          slave combinational read data
// BEHAVIOUR
//   FSM states: IDLE, OWN0, OWN1. Registers: state, last (last served master), cnt.
//   cnt is $clog2(MAX_BURST+1) bits wide and saturates at MAX_BURST.
//   Reset (async, immediate): state=IDLE, last=1 (M0 wins first tie), cnt=0.
//     All outputs are 0 during reset: o_s_we, acks, o_s_addr/access/wdata, rdata.
//   IDLE: slave outputs are 0 and no ack is given.
//     Next state = OWNx for the single requester.
//     On a tie: FIXED_PRIO=1 picks M0; otherwise the master != last.
//     cnt <= 0.
//   OWNx: o_s_* = mux of master x's signals; o_s_we = i_mx_we & i_mx_req.
//     o_mx_ack = i_mx_req (combinational); o_mx_rdata = i_s_rdata; the other ack = 0.
//     Each acked cycle: cnt <= cnt+1 (saturating), last <= x.
//   Latency: req rising in IDLE at cycle N -> ack at N+1.
//     While owned, one transfer per cycle and back-to-back acks.
//   OWNx transitions, evaluated each edge, first match wins:
//     1) i_mx_req & i_mx_lock                      -> stay OWNx
//     2) i_mx_req & (!i_my_req | cnt+1<MAX_BURST)  -> stay OWNx
//     3) i_my_req                                  -> OWNy, cnt <= 0 (direct hand-off, no idle cycle)
//     4) otherwise                                 -> IDLE
//   Req withdrawn before ack: no slave access and no ack is issued for it.
//   The slave bus is never driven by two masters; o_s_we is never 1 outside OWNx.
//   Lock without req is ignored. Lock held indefinitely starves the other master (by design).
//   Reset mid-burst: o_s_we drops combinationally; a write on the same edge as reset assertion is
//     not guaranteed; after release FSM restarts from IDLE, and masters reissue requests.
//   Masters keep addr/we/access/wdata stable while req=1 and no ack.
// TESTING
//   1. M0 word write addr=0x10 data=0xDEADBEEF, then read -> ack 1 cycle after req; rdata=0xDEADBEEF.
//   2. M0,M1 req same cycle from reset, FIXED_PRIO=0 -> M0 owns first;
//      after MAX_BURST=4 acks M1 acked next cycle, alternating thereafter.
//   3. M0 lock=1, 10 cycles continuous req, M1 requesting -> 10 M0 acks, 0 M1 acks,
//      then M1 acked the cycle after M0 drops req.
//   4. FIXED_PRIO=1, both req from IDLE with last=0 -> M0 granted; M1 waiting with no ack.
//   5. i_reset pulsed during M1 write burst -> o_s_we=0 immediately; state IDLE;
//      next tie granted to M0.
//   6. M1 byte write 0xAB to 0x21, M0 word read 0x20 -> M0 sees byte 1 = 0xAB; no overlapping acks.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for a shared data memory port.
// Round-robin or fixed-priority grant, bounded bursts, lock for atomic RMW.
module data_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_m0_req,
    input  logic                  i_m0_lock,
    input  logic                  i_m0_we,
    input  logic [1:0]            i_m0_access,
    input  logic [ADDR_WIDTH-1:0] i_m0_addr,
    input  logic [31:0]           i_m0_wdata,
    output logic                  o_m0_ack,
    output logic [31:0]           o_m0_rdata,
    input  logic                  i_m1_req,
    input  logic                  i_m1_lock,
    input  logic                  i_m1_we,
    input  logic [1:0]            i_m1_access,
    input  logic [ADDR_WIDTH-1:0] i_m1_addr,
    input  logic [31:0]           i_m1_wdata,
    output logic                  o_m1_ack,
    output logic [31:0]           o_m1_rdata,
    output logic [ADDR_WIDTH-1:0] o_s_addr,
    output logic                  o_s_we,
    output logic [1:0]            o_s_access,
    output logic [31:0]           o_s_wdata,
    input  logic [31:0]           i_s_rdata
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic            cnt_room;

    // Compare in 32 bits so cnt+1 cannot wrap in a narrow counter
    assign cnt_room = (32'(cnt_q) + 32'd1) < 32'(MAX_BURST);
    assign cnt_inc  = (cnt_q == CW'(MAX_BURST)) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        o_s_addr   = '0;
        o_s_we     = 1'b0;
        o_s_access = 2'b00;
        o_s_wdata  = 32'h0;
        o_m0_ack   = 1'b0;
        o_m1_ack   = 1'b0;
        o_m0_rdata = 32'h0;
        o_m1_rdata = 32'h0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_m0_req && i_m1_req) begin
                    state_d = ((FIXED_PRIO != 0) || last_q) ? OWN0 : OWN1;
                end else if (i_m0_req) begin
                    state_d = OWN0;
                end else if (i_m1_req) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                o_s_addr   = i_m0_addr;
                o_s_we     = i_m0_we & i_m0_req;
                o_s_access = i_m0_access;
                o_s_wdata  = i_m0_wdata;
                o_m0_ack   = i_m0_req;
                o_m0_rdata = i_s_rdata;
                if (i_m0_req) begin
                    cnt_d  = cnt_inc;
                    last_d = 1'b0;
                end
                if (i_m0_req && i_m0_lock) begin
                    state_d = OWN0;
                end else if (i_m0_req && (!i_m1_req || cnt_room)) begin
                    state_d = OWN0;
                end else if (i_m1_req) begin
                    state_d = OWN1;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN1: begin
                o_s_addr   = i_m1_addr;
                o_s_we     = i_m1_we & i_m1_req;
                o_s_access = i_m1_access;
                o_s_wdata  = i_m1_wdata;
                o_m1_ack   = i_m1_req;
                o_m1_rdata = i_s_rdata;
                if (i_m1_req) begin
                    cnt_d  = cnt_inc;
                    last_d = 1'b1;
                end
                if (i_m1_req && i_m1_lock) begin
                    state_d = OWN1;
                end else if (i_m1_req && (!i_m0_req || cnt_room)) begin
                    state_d = OWN1;
                end else if (i_m0_req) begin
                    state_d = OWN0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
